mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction / data) arbiter in front of a single RAM port.
// Data wins contested grants unless the previous completed grant was data, giving
// strict alternation under sustained contention. Errors and timeouts are reported
// through the normal completion pulse with a poison load value and a sticky memerr.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [WORD_W-1:0] ERR_WORD = 32'hBAD1_BAD1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [WORD_W-1:0] addrQ;
    logic [WORD_W-1:0] storeQ;
    logic              writeQ;
    logic [CNT_W-1:0]  cnt;
    logic              lastData;
    logic              done;
    logic              fault;
    logic              hit;
    logic              err;
    logic              tmo;
    logic [WORD_W-1:0] loadVal;

    // A real ACCESS outranks an error or an expiring counter in the same cycle.
    assign hit = (ramstate == RAM_ACCESS);
    assign err = (ramstate == RAM_ERROR);
    assign tmo = (cnt == CNT_W'(TIMEOUT));

    // Next-state selection and RAM / requester outputs; reset forces the idle view.
    always_comb begin
        stateNext = state;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = '0;
        dload     = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        done      = 1'b0;
        fault     = 1'b0;
        loadVal   = '0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    if ((dREN || dWEN) && !(iREN && lastData)) begin
                        stateNext = DGRANT;
                    end else if (iREN) begin
                        stateNext = IGRANT;
                    end
                end
                IGRANT, DGRANT: begin
                    ramREN   = !writeQ;
                    ramWEN   = writeQ;
                    ramaddr  = addrQ;
                    ramstore = storeQ;
                    if (hit || err || tmo) begin
                        done      = 1'b1;
                        fault     = !hit;
                        stateNext = IDLE;
                        loadVal   = hit ? ramload : ERR_WORD;
                        if (state == IGRANT) begin
                            iwait = 1'b0;
                            iload = loadVal;
                        end else begin
                            dwait = 1'b0;
                            dload = writeQ ? '0 : loadVal;
                        end
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // State, transaction capture, grant-cycle counter, fairness marker and sticky error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            addrQ    <= '0;
            storeQ   <= '0;
            writeQ   <= 1'b0;
            cnt      <= '0;
            lastData <= 1'b0;
            memerr   <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == IDLE) begin
                cnt <= '0;
                if (stateNext == DGRANT) begin
                    addrQ  <= daddr;
                    storeQ <= dstore;
                    writeQ <= dWEN;
                end else if (stateNext == IGRANT) begin
                    addrQ  <= iaddr;
                    storeQ <= '0;
                    writeQ <= 1'b0;
                end
            end else if (done) begin
                lastData <= (state == DGRANT);
                if (fault) begin
                    memerr <= 1'b1;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
